// File: rtl/native_to_wishbone_master_pkg.sv
// native_bus_pkg: shared types and defaults for the native-to-Wishbone bridge.
package native_bus_pkg;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam int          MAX_ADDR_W         = 32;
    localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;

    // Address is stored at the widest supported width; the top slices out its own bits
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [3:0]            strb;
    } req_t;

    function automatic logic is_write(input logic [3:0] strb);
        return |strb;
    endfunction

endpackage

// File: rtl/native_to_wishbone_master_if.sv
// native_to_wishbone_master_if: Wishbone classic bus seen from the bridge (master) and the target (slave).
interface native_to_wishbone_master_if #(
    parameter int address_width = 16
);
    logic [address_width-3:0] o_wb_adr;
    logic [31:0]              o_wb_dat;
    logic [3:0]               o_wb_sel;
    logic                     o_wb_we;
    logic                     o_wb_cyc;
    logic                     o_wb_stb;
    logic [31:0]              i_wb_rdt;
    logic                     i_wb_ack;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
        input  i_wb_rdt, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
        output i_wb_rdt, i_wb_ack
    );
endinterface

// File: rtl/native_to_wishbone_master_req_buffer.sv
// native_req_buffer: one-deep holding slot for a request that arrives while the bridge is busy.
module native_req_buffer
    import native_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  req_t i_req,
    output req_t o_req,
    output logic o_valid
);
    req_t r_req;
    logic r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_req   <= i_push ? i_req : r_req;
            r_valid <= i_push | (r_valid & ~i_pop);
        end
    end

    assign o_req   = r_req;
    assign o_valid = r_valid;
endmodule

// File: rtl/native_to_wishbone_master.sv
// native_to_wishbone_master: turns one-cycle native request pulses into Wishbone classic cycles,
// with a one-entry pending slot and a wait-cycle watchdog that answers with error_data.
module native_to_wishbone_master
    import native_bus_pkg::*;
#(
    parameter int          address_width  = 16,
    parameter int          timeout_cycles = 255,
    parameter logic [31:0] error_data     = DEFAULT_ERROR_DATA
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [address_width-1:0]    address_i,
    input  logic [31:0]                 data_i,
    input  logic [3:0]                  write_strb_i,
    input  logic                        data_valid_i,
    output logic [31:0]                 data_o,
    output logic                        data_valid_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic                        timeout_o,
    native_to_wishbone_master_if.master wb
);
    localparam logic [15:0] LAST_WAIT = 16'(timeout_cycles - 1);

    state_t                   r_state;
    logic [address_width-3:0] r_adr;
    logic [31:0]              r_dat;
    logic [3:0]               r_sel;
    logic                     r_we;
    logic                     r_cyc;
    logic [15:0]              r_cnt;
    logic [31:0]              r_data;
    logic                     r_dv;
    logic                     r_to;
    logic                     r_ovf;

    req_t w_new_req;
    req_t w_buf_req;
    req_t w_load_req;
    logic w_buf_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_load;
    logic w_unused_addr;

    assign w_new_req  = '{addr: MAX_ADDR_W'(address_i), data: data_i, strb: write_strb_i};
    // IDLE always has an empty slot, so the slot takes priority only while in RESP
    assign w_load_req = w_buf_valid ? w_buf_req : w_new_req;
    assign w_push     = data_valid_i && r_state == BUS && !w_buf_valid;
    assign w_pop      = r_state == RESP && w_buf_valid;
    assign w_drop     = data_valid_i && r_state != IDLE && w_buf_valid;
    assign w_load     = (r_state == IDLE && data_valid_i) || (r_state == RESP && (w_buf_valid || data_valid_i));
    assign w_unused_addr = ^w_load_req.addr;

    native_req_buffer u_buf (
        .clk    (clk_i),
        .rst    (reset_i),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_req  (w_new_req),
        .o_req  (w_buf_req),
        .o_valid(w_buf_valid)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_to    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_dv  <= 1'b0;
            r_to  <= 1'b0;
            r_ovf <= w_drop;
            if (w_load) begin
                r_state <= BUS;
                r_adr   <= w_load_req.addr[address_width-1:2];
                r_dat   <= w_load_req.data;
                r_sel   <= is_write(w_load_req.strb) ? w_load_req.strb : 4'hF;
                r_we    <= is_write(w_load_req.strb);
                r_cyc   <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == BUS) begin
                // An ack arriving in the last permitted cycle still completes normally
                if (wb.i_wb_ack || r_cnt == LAST_WAIT) begin
                    r_state <= RESP;
                    r_cyc   <= 1'b0;
                    r_dv    <= 1'b1;
                    r_to    <= ~wb.i_wb_ack;
                    r_data  <= r_we ? 32'h0 : (wb.i_wb_ack ? wb.i_wb_rdt : error_data);
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign wb.o_wb_adr  = r_adr;
    assign wb.o_wb_dat  = r_dat;
    assign wb.o_wb_sel  = r_sel;
    assign wb.o_wb_we   = r_we;
    assign wb.o_wb_cyc  = r_cyc;
    assign wb.o_wb_stb  = r_cyc;
    assign data_o       = r_data;
    assign data_valid_o = r_dv;
    assign busy_o       = r_state != IDLE;
    assign overflow_o   = r_ovf;
    assign timeout_o    = r_to;
endmodule

// File: doc/native_to_wishbone_master.md
NATIVE_TO_WISHBONE_MASTER -- requirements
Module: native_to_wishbone_master

Interface
REQ-001 SHALL have parameter address_width, default 16, native byte-address width.
REQ-002 SHALL have parameter timeout_cycles, default 255, range 1..65535, Wishbone wait cycles before abort.
REQ-003 SHALL have parameter error_data, default 32'hDEADBEEF, read data returned on timeout.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port address_i  input  address_width  native request byte address.
REQ-007 SHALL have port data_i  input  32  native write data.
REQ-008 SHALL have port write_strb_i  input  4  byte strobes; nonzero means write, zero means read.
REQ-009 SHALL have port data_valid_i  input  1  one-cycle native request pulse.
REQ-010 SHALL have port data_o  output  32  native response data.
REQ-011 SHALL have port data_valid_o  output  1  one-cycle native response pulse.
REQ-012 SHALL have port busy_o  output  1  high when state is not IDLE.
REQ-013 SHALL have port overflow_o  output  1  one-cycle pulse when a request is dropped.
REQ-014 SHALL have port timeout_o  output  1  one-cycle pulse, coincident with the abort response.
REQ-015 SHALL have Wishbone ports o_wb_adr (address_width-2, word address = address[address_width-1:2]), o_wb_dat 32, o_wb_sel 4, o_wb_we 1, o_wb_cyc 1, o_wb_stb 1, i_wb_rdt 32, i_wb_ack 1.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP.
REQ-017 IDLE: data_valid_i high SHALL capture address/data/strobes and enter BUS on the next edge.
REQ-018 BUS: o_wb_cyc = o_wb_stb = 1; o_wb_we = |strb; o_wb_sel = strb for writes, 4'hF for reads; adr/dat held constant.
REQ-019 BUS with i_wb_ack high SHALL enter RESP; the read latches i_wb_rdt into data_o, the write latches 32'h0.
REQ-020 BUS SHALL count cycles from entry; when the count reaches timeout_cycles with no ack, SHALL deassert cyc/stb, latch error_data (reads) or 0 (writes), pulse timeout_o, and enter RESP.
REQ-021 Ack in the timeout cycle: ack SHALL win; no timeout_o.
REQ-022 RESP: data_valid_o = 1 for exactly one cycle; next state is BUS if the pending buffer is valid (buffer moved to active), else IDLE.
REQ-023 Latency: request at edge N SHALL give cyc at N+1; ack sampled at edge M SHALL give data_valid_o during cycle M+1.
REQ-024 One-entry pending buffer: data_valid_i in BUS or RESP SHALL be stored if the buffer is empty, else dropped with an overflow_o pulse.
REQ-025 A request in the RESP cycle with an empty buffer SHALL be stored and issued in the immediately following BUS state.
REQ-026 Buffer SHALL be empty whenever state is IDLE.
REQ-027 data_o SHALL hold its value until the next response latch.

Reset
REQ-028 reset_i SHALL immediately force IDLE, empty buffer, counter 0, and all outputs 0 (data_o, o_wb_* included), including mid-BUS cycle.
REQ-029 No response SHALL be generated for a transaction aborted by reset.

Structure
REQ-030 Shared package native_bus_pkg SHALL hold the state enum, the request struct (addr, data, strb), and the default error_data constant.
REQ-031 Pending buffer SHALL be sub-module native_req_buffer (1-deep, push/pop/valid); FSM and counter SHALL reside in the top module.

Verification
REQ-032 Read 0x0010, ack after 2 wait cycles, rdt 0x12345678 -> o_wb_adr 0x0004, sel 4'hF, we 0; data_valid_o pulse with data_o 0x12345678 one cycle after ack.
REQ-033 Write 0x0020 strb 4'b0011 data 0xAABBCCDD, immediate ack -> we 1, sel 4'b0011, dat 0xAABBCCDD; data_valid_o with data_o 0.
REQ-034 Three back-to-back requests while the first stalls -> second buffered and issued after the first response; third dropped with one overflow_o pulse.
REQ-035 timeout_cycles=4, read never acked -> cyc drops after 4 cycles; data_o 0xDEADBEEF, timeout_o and data_valid_o coincident.
REQ-036 Ack in exactly the timeout cycle -> real rdt returned, timeout_o stays 0.
REQ-037 reset_i asserted mid-BUS -> cyc/stb low without a clock edge; no data_valid_o after release; next request behaves as in REQ-032.
